kernel_mac_accumulator: RTL
===========================

# kernel_mac_accumulator

Downstream consumer of the approximate 8:2 compressor multiplier tree. It takes the two redundant output rows (sum row, carry row) of each pixel×coefficient product and resolves them with an exact carry-propagate add. It accumulates TAPS consecutive products into one convolution-window result, then emits a scaled, saturated 8-bit pixel over a valid/ready handshake. It sits between the compressor-based multiplier array and the image write-back path.

## Interface
- IN_W, 16, width of each redundant input row
- TAPS, 9, products per window (3×3 kernel)
- ACC_W, 21, accumulator width; must be ≥ IN_W+1+clog2(TAPS)
- SHIFT, 4, right-shift applied to the final accumulator
- OUT_W, 8, output pixel width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  redundant product pair present
- in_ready  out  1  block accepts the pair this cycle
- in_sum  in  IN_W  compressor sum row
- in_carry  in  IN_W  compressor carry row (already weight-aligned)
- out_valid  out  1  window result available
- out_ready  in  1  downstream takes the result
- out_pixel  out  OUT_W  saturated (acc >> SHIFT)
- out_acc  out  ACC_W  raw window accumulator
- out_sat  out  1  out_pixel was clipped to all-ones

## Operation
- Accept = in_valid && in_ready.
- prod = in_sum + in_carry, exact, IN_W+1 bits, zero-extended. Unsigned throughout.
- FSM states: ACCUM, OUTPUT. Reset state is ACCUM.
- ACCUM:
  - in_ready = 1.
  - On accept: acc <= (tap_cnt==0 ? 0 : acc) + prod, and tap_cnt increments.
  - On accept with tap_cnt==TAPS-1: tap_cnt <= 0, latch the result registers, go to OUTPUT.
- OUTPUT:
  - out_valid = 1; out_pixel, out_acc and out_sat are held stable.
  - in_ready = out_ready.
  - If out_ready: return to ACCUM. If an accept happens in that same cycle, the accepted prod is tap 0 of the next window (acc <= prod, tap_cnt <= 1).
- Scaling: s = acc >> SHIFT. If s > 2^OUT_W−1, then out_pixel = all-ones and out_sat = 1; otherwise out_pixel = s[OUT_W-1:0] and out_sat = 0.
- Accumulator overflow cannot occur under the ACC_W rule. Overflow is not checked.
- Cycles with in_valid=0 in ACCUM change nothing.

## Timing
- Reset values: state=ACCUM, tap_cnt=0, acc=0, out_valid=0, out_pixel=0, out_acc=0, out_sat=0, in_ready=1 (combinational from state).
- Latency: the final tap accepted in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one window per TAPS cycles when out_ready is held high. There is no bubble between windows.
- in_ready depends combinationally on out_ready only in OUTPUT state. There is no combinational path from in_valid to any output.
- Reset mid-window discards the partial accumulator and tap count. The next accepted pair is tap 0.
- Reset while in OUTPUT drops the pending result. out_valid=0 in the following cycle.
- Output registers are held unchanged while out_valid=1 and out_ready=0.

## Structure
- Shared package/include `approx_img_pkg`:
  - default constants IMG_PIX_W=8, KERNEL_TAPS=9, PROD_ROW_W=16
  - the clog2 helper
  - so the compressor tree and this block agree on widths
- One sub-module `exact_cpa_rows`: parameterised IN_W exact adder of sum/carry rows to IN_W+1 bits. It is combinational, and is kept exact so that compressor error studies isolate the compressor.
- FSM, tap counter, accumulator and saturation logic live in the top module.

## Test plan
- Nine pairs of sum=100, carry=28 (prod 128), out_ready=1 → out_acc=1152, out_pixel=72, out_sat=0; out_valid rises exactly one cycle after the 9th accept.
- Nine pairs of sum=carry=16'hFFFF → out_acc=1179630, out_pixel=255, out_sat=1.
- Complete a window with out_ready=0 for 5 cycles → in_ready=0 and outputs stable for all 5 cycles. Then out_ready=1 → returns to ACCUM on the next cycle.
- In OUTPUT with out_ready=1 and in_valid=1 (prod 10) in the same cycle → the next window's out_acc includes 10 as tap 0. Back-to-back windows show no idle cycle.
- Accept 4 taps of prod 1000, assert rst for one cycle, then 9 taps of prod 16 → out_acc=144 and out_pixel=9. Outputs read 0 immediately after rst.
- Random in_valid gaps (about 50%) over 100 windows against a reference model → every out_acc, out_pixel and out_sat matches.

Source files
------------

// File: rtl/approx_img_pkg.sv
// Widths and helpers shared by the compressor multiplier tree and its consumers,
// so both sides agree on row, tap and pixel sizes.
package approx_img_pkg;
    localparam int IMG_PIX_W   = 8;
    localparam int KERNEL_TAPS = 9;
    localparam int PROD_ROW_W  = 16;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_OUTPUT = 1'b1
    } mac_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/exact_cpa_rows.sv
// Exact carry-propagate add of the compressor's sum and carry rows. Kept exact so
// that error studies of the approximate compressor are not polluted by this stage.
module exact_cpa_rows #(
    parameter int IN_W = 16
) (
    input  logic [IN_W-1:0] sum_row,
    input  logic [IN_W-1:0] carry_row,
    output logic [IN_W:0]   prod
);
    assign prod = {1'b0, sum_row} + {1'b0, carry_row};
endmodule

// File: rtl/kernel_mac_accumulator.sv
// Resolves redundant product rows, accumulates one convolution window of TAPS
// products and hands out a scaled, saturated pixel over valid/ready.
module kernel_mac_accumulator
    import approx_img_pkg::*;
#(
    parameter int IN_W  = PROD_ROW_W,
    parameter int TAPS  = KERNEL_TAPS,
    parameter int ACC_W = 21,
    parameter int SHIFT = 4,
    parameter int OUT_W = IMG_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic [IN_W-1:0]  in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_pixel,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat
);
    localparam int CNT_W = (clog2(TAPS) < 1) ? 1 : clog2(TAPS);
    localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    mac_state_t       state;
    logic [CNT_W-1:0] tap_cnt;
    logic [ACC_W-1:0] acc;

    logic [IN_W:0]    prod;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] scaled;
    logic             sat_next;
    logic             accept;

    exact_cpa_rows #(.IN_W(IN_W)) u_cpa (
        .sum_row   (in_sum),
        .carry_row (in_carry),
        .prod      (prod)
    );

    // In OUTPUT the only way to accept is together with the result being taken.
    assign in_ready = (state == ST_ACCUM) || out_ready;
    assign accept   = in_valid && in_ready;

    // tap_cnt is 0 whenever in OUTPUT, so the first tap of a new window restarts acc.
    assign acc_next = ((tap_cnt == '0) ? '0 : acc) + ACC_W'(prod);
    assign scaled   = acc_next >> SHIFT;
    assign sat_next = scaled > PIX_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACCUM;
            tap_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (state == ST_OUTPUT && out_ready) begin
                state     <= ST_ACCUM;
                out_valid <= 1'b0;
            end
            if (accept) begin
                acc <= acc_next;
                if (tap_cnt == LAST_TAP) begin
                    tap_cnt   <= '0;
                    out_acc   <= acc_next;
                    out_pixel <= sat_next ? '1 : scaled[OUT_W-1:0];
                    out_sat   <= sat_next;
                    out_valid <= 1'b1;
                    state     <= ST_OUTPUT;
                end else begin
                    tap_cnt <= tap_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule
